// File: rtl/moving_average2_checker_if.sv
// Stimulus/response and status bundle between the moving-average checker and its filter side.
interface moving_average2_checker_if;
  logic              start;
  logic signed [7:0] eta_o;
  logic signed [7:0] topLet_i;
  logic              busy;
  logic              done;
  logic              pass;
  logic        [7:0] err_count;
  logic        [7:0] first_err_idx;

  modport master (
    input  start,
    input  topLet_i,
    output eta_o,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_err_idx
  );

  modport slave (
    output start,
    output topLet_i,
    input  eta_o,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_err_idx
  );
endinterface

// File: rtl/moving_average2_checker.sv
// Drives the two-tap moving-average filter with an LFSR sequence and checks every response
// against a bit-exact model delayed by the filter latency.
module moving_average2_checker #(
  parameter int unsigned N_SAMPLES = 64,
  parameter int unsigned LATENCY   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic                       system1000,
  input logic                       system1000_rst,
  moving_average2_checker_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [7:0] SeedEff    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [8:0] LastSample = 9'(N_SAMPLES - 1);
  localparam logic [8:0] LastCmp    = 9'(N_SAMPLES + LATENCY - 1);
  localparam logic [8:0] LatCnt     = 9'(LATENCY);

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  state_e            state_q, state_d;
  logic        [7:0] lfsr_q, lfsr_d;
  logic signed [7:0] eta_q, eta_d;
  logic signed [7:0] x_prev_q, x_prev_d;
  logic        [8:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic        [7:0] err_q, err_d;
  logic        [7:0] first_q, first_d;

  logic signed [8:0] sum;
  logic signed [7:0] exp_cur;
  logic signed [7:0] exp_del;
  logic              cmp_active;
  logic              mismatch;
  logic        [7:0] cmp_idx;

  // 9-bit sum, arithmetic shift right by one, keep the low 8 bits.
  assign sum     = {eta_q[7], eta_q} + {x_prev_q[7], x_prev_q};
  assign exp_cur = sum[8:1];

  if (LATENCY == 0) begin : g_no_delay
    assign exp_del = exp_cur;
  end else begin : g_delay
    logic signed [7:0] pipe_q [LATENCY];

    always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
        for (int i = 0; i < LATENCY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= exp_cur;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign exp_del = pipe_q[LATENCY-1];
  end

  // cnt_q counts busy cycles; the compare for sample index cnt_q-LATENCY lands in that cycle.
  assign cmp_idx  = cnt_q[7:0] - LatCnt[7:0];
  assign mismatch = (bus.topLet_i != exp_del);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    eta_d      = eta_q;
    x_prev_d   = x_prev_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    first_d    = first_q;
    cmp_active = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StRun;
          eta_d    = SeedEff;
          lfsr_d   = lfsr_next(SeedEff);
          x_prev_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = '0;
          first_d  = 8'hFF;
        end
      end
      StRun: begin
        x_prev_d   = eta_q;
        cmp_active = (cnt_q >= LatCnt);
        cnt_d      = cnt_q + 9'd1;
        if (cnt_q == LastSample) begin
          eta_d = '0;
          if (LATENCY == 0) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end else begin
          eta_d  = lfsr_q;
          lfsr_d = lfsr_next(lfsr_q);
        end
      end
      StDrain: begin
        x_prev_d   = eta_q;
        cmp_active = 1'b1;
        cnt_d      = cnt_q + 9'd1;
        if (cnt_q == LastCmp) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cmp_active && mismatch) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
      if (first_q == 8'hFF) begin
        first_d = cmp_idx;
      end
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q  <= StIdle;
      lfsr_q   <= SeedEff;
      eta_q    <= '0;
      x_prev_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      eta_q    <= eta_d;
      x_prev_q <= x_prev_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign bus.eta_o         = eta_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = done_q && (err_q == 8'd0);
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule
